// File: rtl/wb_dnn_mac_engine.sv
// Wishbone-slave DNN MAC engine: activation FIFO feeding a LANES-wide signed
// multiply/accumulate array with CSR control, status and a level completion interrupt.
module wb_dnn_mac_engine #(
    parameter logic [31:0] ADDR_BASE  = 32'h3000_0000,
    parameter int          LANES      = 4,
    parameter int          DW         = 8,
    parameter int          ACC_W      = 24,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        irq
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int WW = LANES * DW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic logic signed [2*DW-1:0] mul_s(input logic signed [DW-1:0] a,
                                                      input logic signed [DW-1:0] b);
        return (2*DW)'(a) * (2*DW)'(b);
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] acc,
                                                         input logic signed [2*DW-1:0] p);
        logic signed [ACC_W:0] s;
        s = (ACC_W+1)'(acc) + (ACC_W+1)'(p);
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return s[ACC_W-1:0];
    endfunction

    logic                   ack_q;
    logic [31:0]            dat_q, rdata;
    logic [1:0]             state_q, state_d;
    logic                   done_q, done_d, ovf_q, ovf_d, irq_en_q, irq_en_d, irq_q;
    logic [7:0]             len_q, len_d, wcnt_q, wcnt_d;
    logic [AW-1:0]          rp_q, wp_q;
    logic [CW-1:0]          fcnt_q;
    logic [WW-1:0]          mem_q [FIFO_DEPTH];
    logic signed [DW-1:0]   w_q [LANES];
    logic signed [DW-1:0]   act_p0_q [LANES];
    logic signed [2*DW-1:0] prod_p1_q [LANES];
    logic                   vld_p0_q, vld_p1_q;
    logic signed [ACC_W-1:0] acc_q [LANES];

    logic       hit, wr, lane_ok, is_ctrl, is_stat, is_data, is_wgt, is_acc;
    logic [7:0] off;
    logic [1:0] lidx;
    logic       full, empty, busy, push, pop, ovf_set, start, clr_ok;
    logic       unused_sel;

    assign unused_sel = ^wbs_sel_i;
    assign hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == ADDR_BASE[31:8]) & ~ack_q;
    assign wr      = hit & wbs_we_i;
    assign off     = wbs_adr_i[7:0];
    assign lidx    = off[3:2];
    assign lane_ok = (int'(lidx) < LANES) && (off[1:0] == 2'b00);
    assign is_ctrl = (off == 8'h00);
    assign is_stat = (off == 8'h04);
    assign is_data = (off == 8'h08);
    assign is_wgt  = (off[7:4] == 4'h1) && lane_ok;
    assign is_acc  = (off[7:4] == 4'h4) && lane_ok;

    assign full    = (fcnt_q == CW'(FIFO_DEPTH));
    assign empty   = (fcnt_q == '0);
    assign busy    = (state_q == S_RUN);
    // Overflow is judged on the pre-cycle count, so a same-cycle pop never rescues a push.
    assign push    = wr & is_data & ~full;
    assign ovf_set = wr & is_data & full;
    assign pop     = busy & ~empty & (wcnt_q != len_q);
    assign start   = wr & is_ctrl & wbs_dat_i[0];
    assign clr_ok  = wr & is_ctrl & wbs_dat_i[1] & ~busy;

    always_comb begin
        state_d  = state_q;
        done_d   = done_q;
        wcnt_d   = wcnt_q;
        len_d    = len_q;
        irq_en_d = irq_en_q;
        ovf_d    = ovf_q | ovf_set;
        if (wr && is_ctrl) begin
            irq_en_d = wbs_dat_i[2];
            if (!busy) len_d = wbs_dat_i[15:8];
        end
        if (wr && is_stat) begin
            if (wbs_dat_i[1]) done_d = 1'b0;
            if (wbs_dat_i[4]) ovf_d = 1'b0;
        end
        case (state_q)
            S_RUN: begin
                if (pop) begin
                    wcnt_d = wcnt_q + 8'd1;
                end else if (wcnt_q == len_q && !vld_p0_q && !vld_p1_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                if (start) begin
                    wcnt_d = '0;
                    if (wbs_dat_i[15:8] == 8'd0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        done_d  = 1'b0;
                    end
                end
            end
        endcase
    end

    always_comb begin
        rdata = '0;
        if (is_ctrl)      rdata = {16'd0, len_q, 5'd0, irq_en_q, 2'b00};
        else if (is_stat) rdata = {16'd0, 8'(fcnt_q), 3'd0, ovf_q, empty, full, done_q, busy};
        else if (is_wgt)  rdata = 32'(w_q[lidx]);
        else if (is_acc)  rdata = 32'(acc_q[lidx]);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            state_q  <= S_IDLE;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
            len_q    <= '0;
            wcnt_q   <= '0;
            rp_q     <= '0;
            wp_q     <= '0;
            fcnt_q   <= '0;
            vld_p0_q <= 1'b0;
            vld_p1_q <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                w_q[i]   <= '0;
                acc_q[i] <= '0;
            end
        end else begin
            ack_q    <= hit;
            dat_q    <= (hit && !wbs_we_i) ? rdata : '0;
            state_q  <= state_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            irq_en_q <= irq_en_d;
            irq_q    <= done_q & irq_en_q;
            len_q    <= len_d;
            wcnt_q   <= wcnt_d;
            if (push) wp_q <= wp_q + AW'(1);
            if (pop)  rp_q <= rp_q + AW'(1);
            fcnt_q   <= fcnt_q + CW'(push) - CW'(pop);
            vld_p0_q <= pop;
            vld_p1_q <= vld_p0_q;
            if (wr && is_wgt) w_q[lidx] <= wbs_dat_i[DW-1:0];
            // p2: accumulate with saturation
            for (int i = 0; i < LANES; i++) begin
                if (clr_ok)        acc_q[i] <= '0;
                else if (vld_p1_q) acc_q[i] <= sat_add(acc_q[i], prod_p1_q[i]);
            end
        end
    end

    // p0: pop FIFO head into lane activations; p1: register products
    always_ff @(posedge wb_clk_i) begin
        if (push) mem_q[wp_q] <= wbs_dat_i[WW-1:0];
        for (int i = 0; i < LANES; i++) begin
            if (pop) act_p0_q[i] <= mem_q[rp_q][i*DW +: DW];
            prod_p1_q[i] <= mul_s(act_p0_q[i], w_q[i]);
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq       = irq_q;
endmodule

// File: tb/tb_wb_dnn_mac_engine.sv
// Directed testbench for wb_dnn_mac_engine: CSR access, MAC results, FIFO limits,
// saturation, zero-length runs, mid-run reset and address decode.
module tb_wb_dnn_mac_engine;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] CTRL = BASE + 32'h00;
    localparam logic [31:0] STAT = BASE + 32'h04;
    localparam logic [31:0] DIN  = BASE + 32'h08;
    localparam logic [31:0] WGT  = BASE + 32'h10;
    localparam logic [31:0] ACC  = BASE + 32'h40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic        irq;
    int          checks = 0;
    int          errors = 0;

    wb_dnn_mac_engine #(.ADDR_BASE(BASE), .LANES(4), .DW(8), .ACC_W(24), .FIFO_DEPTH(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d;
        do begin
            @(posedge clk); #1; n++;
        end while (!ack && n < 6);
        if (!ack) begin
            checks++; errors++;
            $display("FAIL write_ack addr=%h: ack=%b, required 1", a, ack);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d, output bit ok);
        int n = 0;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
        do begin
            @(posedge clk); #1; n++;
        end while (!ack && n < 6);
        ok = ack;
        d  = ack ? rdat : 'x;
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic wait_done();
        logic [31:0] s;
        bit ok;
        int n = 0;
        do begin
            wb_read(STAT, s, ok); n++;
        end while (s[1] !== 1'b1 && n < 400);
        checks++;
        if (s[1] !== 1'b1) begin
            errors++;
            $display("FAIL wait_done: status=%h, required done bit set", s);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        bit ok;
        checks++;
        if ({ack, irq, rdat} !== 34'd0) begin
            errors++; $display("FAIL reset_outputs: ack=%b irq=%b dat=%h, required all 0", ack, irq, rdat);
        end
        wb_read(STAT, d, ok); checks++;
        if (d !== 32'h0000_0008) begin
            errors++; $display("FAIL reset_status: got %h, required 00000008", d);
        end
        wb_read(CTRL, d, ok); checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL reset_ctrl: got %h, required 00000000", d);
        end
        wb_read(ACC + 32'hC, d, ok); checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL reset_acc3: got %h, required 00000000", d);
        end
    endtask

    task automatic test_basic_mac();
        logic [31:0] d;
        bit ok;
        logic [31:0] exp_acc [4] = '{32'd2, 32'd8, 32'd18, 32'hFFFF_FFF8};
        wb_write(WGT + 32'h0, 32'd1);
        wb_write(WGT + 32'h4, 32'd2);
        wb_write(WGT + 32'h8, 32'd3);
        wb_write(WGT + 32'hC, 32'hFFFF_FFFF);
        wb_read(WGT + 32'hC, d, ok); checks++;
        if (d !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL weight3_readback: got %h, required ffffffff", d);
        end
        wb_write(DIN, 32'h0403_0201);
        wb_write(DIN, 32'h0403_0201);
        wb_write(CTRL, 32'h0000_0205);
        wait_done();
        for (int i = 0; i < 4; i++) begin
            wb_read(ACC + 32'(4 * i), d, ok); checks++;
            if (d !== exp_acc[i]) begin
                errors++; $display("FAIL basic_acc%0d: got %h, required %h", i, d, exp_acc[i]);
            end
        end
        wb_read(STAT, d, ok); checks++;
        if (d !== 32'h0000_000A) begin
            errors++; $display("FAIL basic_status: got %h, required 0000000a", d);
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL basic_irq_set: irq=%b, required 1", irq);
        end
        wb_write(STAT, 32'h0000_0002);
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL irq_hold_one_cycle: irq=%b, required 1", irq);
        end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_clear: irq=%b, required 0", irq);
        end
    endtask

    task automatic test_fifo_overflow();
        logic [31:0] d;
        bit ok;
        logic [31:0] exp_acc [4] = '{32'd10, 32'd24, 32'd42, 32'hFFFF_FFF0};
        for (int k = 0; k < 8; k++) wb_write(DIN, 32'h0101_0101);
        wb_write(DIN, 32'h7F7F_7F7F);
        wb_read(STAT, d, ok); checks++;
        if (d !== 32'h0000_0814) begin
            errors++; $display("FAIL fifo_full_status: got %h, required 00000814", d);
        end
        wb_write(CTRL, 32'h0000_0805);
        wait_done();
        wb_read(STAT, d, ok); checks++;
        if (d !== 32'h0000_001A) begin
            errors++; $display("FAIL fifo_drain_status: got %h, required 0000001a", d);
        end
        for (int i = 0; i < 4; i++) begin
            wb_read(ACC + 32'(4 * i), d, ok); checks++;
            if (d !== exp_acc[i]) begin
                errors++; $display("FAIL fifo_acc%0d: got %h, required %h", i, d, exp_acc[i]);
            end
        end
        wb_write(STAT, 32'h0000_0012);
        wb_read(STAT, d, ok); checks++;
        if (d !== 32'h0000_0008) begin
            errors++; $display("FAIL w1c_status: got %h, required 00000008", d);
        end
    endtask

    task automatic test_saturation();
        logic [31:0] d;
        bit ok;
        logic [31:0] exp0 [3] = '{32'h003F_C00A, 32'h007F_800A, 32'h007F_FFFF};
        logic [31:0] exp3 [3] = '{32'h003F_BFF0, 32'h007F_7FF0, 32'h007F_FFFF};
        for (int i = 0; i < 4; i++) wb_write(WGT + 32'(4 * i), 32'h0000_0080);
        for (int r = 0; r < 3; r++) begin
            wb_write(CTRL, 32'h0000_FF05);
            for (int k = 0; k < 255; k++) wb_write(DIN, 32'h8080_8080);
            wait_done();
            wb_read(ACC, d, ok); checks++;
            if (d !== exp0[r]) begin
                errors++; $display("FAIL sat_run%0d_acc0: got %h, required %h", r, d, exp0[r]);
            end
            wb_read(ACC + 32'hC, d, ok); checks++;
            if (d !== exp3[r]) begin
                errors++; $display("FAIL sat_run%0d_acc3: got %h, required %h", r, d, exp3[r]);
            end
        end
        wb_write(CTRL, 32'h0000_0002);
        for (int i = 0; i < 4; i++) begin
            wb_read(ACC + 32'(4 * i), d, ok); checks++;
            if (d !== 32'h0) begin
                errors++; $display("FAIL clear_acc%0d: got %h, required 00000000", i, d);
            end
        end
    endtask

    task automatic test_len_zero();
        logic [31:0] d;
        bit ok;
        wb_write(STAT, 32'h0000_0002);
        wb_write(DIN, 32'h0101_0101);
        wb_read(STAT, d, ok); checks++;
        if (d !== 32'h0000_0100) begin
            errors++; $display("FAIL len0_pre_status: got %h, required 00000100", d);
        end
        wb_write(CTRL, 32'h0000_0005);
        wb_read(STAT, d, ok); checks++;
        if (d !== 32'h0000_0102) begin
            errors++; $display("FAIL len0_status: got %h, required 00000102", d);
        end
        wb_read(ACC, d, ok); checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL len0_acc0: got %h, required 00000000", d);
        end
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL len0_irq: irq=%b, required 1", irq);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] d;
        bit ok;
        for (int k = 0; k < 4; k++) wb_write(DIN, 32'h0101_0101);
        wb_write(CTRL, 32'h0000_0505);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({ack, irq, rdat} !== 34'd0) begin
            errors++; $display("FAIL midrun_reset_outputs: ack=%b irq=%b dat=%h, required all 0", ack, irq, rdat);
        end
        rst = 1'b0;
        wb_read(STAT, d, ok); checks++;
        if (d !== 32'h0000_0008) begin
            errors++; $display("FAIL midrun_reset_status: got %h, required 00000008", d);
        end
        for (int i = 0; i < 4; i++) begin
            wb_read(ACC + 32'(4 * i), d, ok); checks++;
            if (d !== 32'h0) begin
                errors++; $display("FAIL midrun_reset_acc%0d: got %h, required 00000000", i, d);
            end
        end
    endtask

    task automatic test_decode_and_busy_start();
        logic [31:0] d;
        bit ok;
        logic [31:0] exp_acc [4] = '{32'd12, 32'd9, 32'd6, 32'd3};
        wb_read(BASE + 32'h30, d, ok); checks++;
        if (ok !== 1'b1 || d !== 32'h0) begin
            errors++; $display("FAIL unmapped_read: ack=%b data=%h, required ack 1 data 00000000", ok, d);
        end
        wb_write(BASE + 32'h30, 32'hDEAD_BEEF);
        wb_read(DIN, d, ok); checks++;
        if (d !== 32'h0) begin
            errors++; $display("FAIL datain_read: got %h, required 00000000", d);
        end
        wb_read(BASE + 32'h100, d, ok); checks++;
        if (ok !== 1'b0) begin
            errors++; $display("FAIL nomatch_ack: ack=%b, required 0", ok);
        end
        for (int i = 0; i < 4; i++) wb_write(WGT + 32'(4 * i), 32'd1);
        wb_write(CTRL, 32'h0000_0305);
        wb_read(STAT, d, ok); checks++;
        if (d !== 32'h0000_0009) begin
            errors++; $display("FAIL busy_status: got %h, required 00000009", d);
        end
        wb_write(CTRL, 32'h0000_0501);
        wb_read(STAT, d, ok); checks++;
        if (d !== 32'h0000_0009) begin
            errors++; $display("FAIL busy_start_status: got %h, required 00000009", d);
        end
        wb_read(CTRL, d, ok); checks++;
        if (d !== 32'h0000_0300) begin
            errors++; $display("FAIL busy_start_ctrl: got %h, required 00000300", d);
        end
        for (int k = 0; k < 3; k++) wb_write(DIN, 32'h0102_0304);
        wait_done();
        wb_read(STAT, d, ok); checks++;
        if (d !== 32'h0000_000A) begin
            errors++; $display("FAIL busy_run_status: got %h, required 0000000a", d);
        end
        for (int i = 0; i < 4; i++) begin
            wb_read(ACC + 32'(4 * i), d, ok); checks++;
            if (d !== exp_acc[i]) begin
                errors++; $display("FAIL busy_run_acc%0d: got %h, required %h", i, d, exp_acc[i]);
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_basic_mac();
        test_fifo_overflow();
        test_saturation();
        test_len_zero();
        test_reset_mid_run();
        test_decode_and_busy_start();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
